commit_trace_buffer: RTL and testbench

- Synthesizable retirement-trace capture block for the pipelined processor.
- Sits beside writeback: one commit event per cycle from the retire stage.
- Classifies each commit (reg write, load, store, store-update, branch/nop, halt), stamps it with an instruction number and buffers it in a parametrised FIFO.
- A valid/ready drain port feeds the trace dumper or a debug UART; halt triggers drain-and-done.

---
 rtl/commit_trace_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Retirement-trace capture: classifies each commit, stamps it with an instruction number, and queues it for a valid/ready drain.
// Optional TRACE_CYCLE_STAMP_EN adds a free-running cycle counter and a per-entry out_cycle field.
//
// state | meaning
// IDLE  | capture disarmed, queued entries remain drainable
// RUN   | commits are captured
// DRAIN | halt seen, commits ignored until the queue empties
// DONE  | halt captured and queue empty; holds until reset
module commit_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trace_en,
  input  logic              cm_valid,
  input  logic [DATA_W-1:0] cm_pc,
  input  logic [DATA_W-1:0] cm_inst,
  input  logic              cm_reg_write,
  input  logic [REG_W-1:0]  cm_write_reg,
  input  logic [DATA_W-1:0] cm_write_data,
  input  logic              cm_mem_read,
  input  logic              cm_mem_write,
  input  logic [DATA_W-1:0] cm_mem_addr,
  input  logic [DATA_W-1:0] cm_mem_data,
  input  logic              cm_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_type,
  output logic [CNT_W-1:0]  out_inum,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic [REG_W-1:0]  out_reg,
  output logic [DATA_W-1:0] out_rdata,
  output logic [DATA_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_mdata,
  output logic [CNT_W-1:0]  ovf_cnt,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [CNT_W-1:0]  out_cycle,
`endif
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] T_NOP  = 3'd0;
  localparam logic [2:0] T_REG  = 3'd1;
  localparam logic [2:0] T_LD   = 3'd2;
  localparam logic [2:0] T_ST   = 3'd3;
  localparam logic [2:0] T_STU  = 3'd4;
  localparam logic [2:0] T_HALT = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CNT_W-1:0]  cycle;
`endif
    logic [2:0]        typ;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] inum_q, inum_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [CNT_W-1:0] cyc_q;
`endif

  entry_t new_e;
  entry_t head;
  logic   accept, full, pop, push;

  assign full   = (count_q == FULL_CNT);
  assign pop    = out_ready && (count_q != '0);
  assign accept = cm_valid && (state_q == S_RUN);
  // A full queue still takes a push when the head leaves in the same cycle.
  assign push   = accept && (!full || pop);

  always_comb begin
    new_e      = '0;
    new_e.pc   = cm_pc;
    new_e.inst = cm_inst;
    new_e.inum = inum_q;
`ifdef TRACE_CYCLE_STAMP_EN
    new_e.cycle = cyc_q;
`endif
    if (cm_halt) begin
      new_e.typ = T_HALT;
    end else if (cm_reg_write && cm_mem_write) begin
      new_e.typ   = T_STU;
      new_e.rg    = cm_write_reg;
      new_e.rdata = cm_write_data;
      new_e.addr  = cm_mem_addr;
      new_e.mdata = cm_mem_data;
    end else if (cm_reg_write && cm_mem_read) begin
      new_e.typ   = T_LD;
      new_e.rg    = cm_write_reg;
      new_e.rdata = cm_write_data;
      new_e.addr  = cm_mem_addr;
    end else if (cm_reg_write) begin
      new_e.typ   = T_REG;
      new_e.rg    = cm_write_reg;
      new_e.rdata = cm_write_data;
    end else if (cm_mem_write) begin
      new_e.typ   = T_ST;
      new_e.addr  = cm_mem_addr;
      new_e.mdata = cm_mem_data;
    end else begin
      new_e.typ = T_NOP;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    inum_d   = inum_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_e;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
    // Dropped commits still consume a number so the gap shows downstream.
    if (accept) inum_d = inum_q + CNT_W'(1);
    if (accept && !push && (ovf_q != '1)) ovf_d = ovf_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trace_en) state_d = S_RUN;
      S_RUN: begin
        if (accept && cm_halt) state_d = S_DRAIN;
        else if (!trace_en)    state_d = S_IDLE;
      end
      S_DRAIN: if (count_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      inum_q   <= '0;
      ovf_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      inum_q   <= inum_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_q + CNT_W'(1);
  end
  assign out_cycle = head.cycle;
`endif

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_type  = head.typ;
  assign out_inum  = head.inum;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_reg   = head.rg;
  assign out_rdata = head.rdata;
  assign out_addr  = head.addr;
  assign out_mdata = head.mdata;
  assign ovf_cnt   = ovf_q;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: expected entries queued at commit time, compared at pop.
module tb_commit_trace_buffer;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 32;

  localparam logic [2:0] K_NOP = 3'd0, K_REG = 3'd1, K_LD = 3'd2, K_ST = 3'd3, K_STU = 3'd4, K_HALT = 3'd5;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              trace_en = 1'b0;
  logic              cm_valid = 1'b0;
  logic [DATA_W-1:0] cm_pc = '0, cm_inst = '0, cm_write_data = '0, cm_mem_addr = '0, cm_mem_data = '0;
  logic [REG_W-1:0]  cm_write_reg = '0;
  logic              cm_reg_write = 1'b0, cm_mem_read = 1'b0, cm_mem_write = 1'b0, cm_halt = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2:0]        out_type;
  logic [CNT_W-1:0]  out_inum;
  logic [DATA_W-1:0] out_pc, out_inst, out_rdata, out_addr, out_mdata;
  logic [REG_W-1:0]  out_reg;
  logic [CNT_W-1:0]  ovf_cnt;
  logic              done;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [CNT_W-1:0]  out_cycle;
`endif

  commit_trace_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .cm_valid(cm_valid),
    .cm_pc(cm_pc), .cm_inst(cm_inst), .cm_reg_write(cm_reg_write),
    .cm_write_reg(cm_write_reg), .cm_write_data(cm_write_data),
    .cm_mem_read(cm_mem_read), .cm_mem_write(cm_mem_write),
    .cm_mem_addr(cm_mem_addr), .cm_mem_data(cm_mem_data), .cm_halt(cm_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_inum(out_inum), .out_pc(out_pc), .out_inst(out_inst), .out_reg(out_reg),
    .out_rdata(out_rdata), .out_addr(out_addr), .out_mdata(out_mdata),
    .ovf_cnt(ovf_cnt),
`ifdef TRACE_CYCLE_STAMP_EN
    .out_cycle(out_cycle),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        typ;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc, inst, rdata, addr, mdata;
    logic [REG_W-1:0]  rg;
    logic [CNT_W-1:0]  cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_state = M_IDLE;
  int          m_cnt = 0;
  logic [CNT_W-1:0] m_inum = '0, m_ovf = '0, m_cyc = '0;
  logic [2:0]  cur_kind = K_NOP;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check outputs, advance the reference model, then clock.
  task automatic step();
    exp_t e;
    bit   pop, acc, pushed;
    chk("out_valid", out_valid, 64'(m_cnt != 0));
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("done", done, 64'(m_state == M_DONE));
    pop = out_ready && (m_cnt != 0);
    if (pop) begin
      e = sb.pop_front();
      chk("out_type", out_type, e.typ);
      chk("out_inum", out_inum, e.inum);
      chk("out_pc", out_pc, e.pc);
      chk("out_inst", out_inst, e.inst);
      chk("out_reg", out_reg, e.rg);
      chk("out_rdata", out_rdata, e.rdata);
      chk("out_addr", out_addr, e.addr);
      chk("out_mdata", out_mdata, e.mdata);
`ifdef TRACE_CYCLE_STAMP_EN
      chk("out_cycle", out_cycle, e.cyc);
`endif
    end
    acc = cm_valid && (m_state == M_RUN);
    pushed = 0;
    if (acc) begin
      e.typ   = cur_kind;
      e.inum  = m_inum;
      e.pc    = cm_pc;
      e.inst  = cm_inst;
      e.cyc   = m_cyc;
      e.rg    = (cur_kind inside {K_REG, K_LD, K_STU}) ? cm_write_reg : '0;
      e.rdata = (cur_kind inside {K_REG, K_LD, K_STU}) ? cm_write_data : '0;
      e.addr  = (cur_kind inside {K_LD, K_ST, K_STU}) ? cm_mem_addr : '0;
      e.mdata = (cur_kind inside {K_ST, K_STU}) ? cm_mem_data : '0;
      m_inum++;
      if (m_cnt < DEPTH || pop) begin
        sb.push_back(e);
        pushed = 1;
      end else if (m_ovf != '1) begin
        m_ovf++;
      end
    end
    m_cnt = m_cnt + int'(pushed) - int'(pop);
    case (m_state)
      M_IDLE:  if (trace_en) m_state = M_RUN;
      M_RUN:   if (acc && cm_halt) m_state = M_DRAIN; else if (!trace_en) m_state = M_IDLE;
      M_DRAIN: if (m_cnt == 0) m_state = M_DONE;
      default: ;
    endcase
    @(posedge clk);
    #1;
    m_cyc++;
  endtask

  task automatic commit(input logic [2:0] kind, input logic [15:0] pc, input logic [2:0] rg,
                        input logic [15:0] rd, input logic [15:0] ad, input logic [15:0] md);
    cur_kind      = kind;
    cm_valid      = 1'b1;
    cm_pc         = pc;
    cm_inst       = {pc[7:0], 8'hE7};
    cm_write_reg  = rg;
    cm_write_data = rd;
    cm_mem_addr   = ad;
    cm_mem_data   = md;
    cm_reg_write  = kind inside {K_REG, K_LD, K_STU, K_HALT};
    cm_mem_read   = kind inside {K_LD, K_STU, K_NOP};
    cm_mem_write  = kind inside {K_ST, K_STU};
    cm_halt       = (kind == K_HALT);
    step();
    cm_valid = 1'b0;
    cm_reg_write = 1'b0; cm_mem_read = 1'b0; cm_mem_write = 1'b0; cm_halt = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trace_en = 1'b0; cm_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_out_inum", out_inum, 0);
`ifdef TRACE_CYCLE_STAMP_EN
    chk("rst_out_cycle", out_cycle, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    m_state = M_IDLE; m_cnt = 0; m_inum = '0; m_ovf = '0; m_cyc = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Single REG commit, one-cycle latency
    do_reset();
    trace_en = 1'b1; out_ready = 1'b1;
    step();
    commit(K_REG, 16'h0002, 3'd3, 16'h00AB, 16'h7777, 16'h6666);
    idle(3);

    // Back-to-back mixed types, unused fields zeroed
    do_reset();
    trace_en = 1'b1; out_ready = 1'b1;
    step();
    commit(K_LD,  16'h0010, 3'd1, 16'h1111, 16'h0010, 16'hDEAD);
    commit(K_ST,  16'h0012, 3'd2, 16'h2222, 16'h0012, 16'h5555);
    commit(K_STU, 16'h0014, 3'd4, 16'h3333, 16'h0014, 16'h4444);
    commit(K_NOP, 16'h0016, 3'd5, 16'h9999, 16'h8888, 16'h7777);
    trace_en = 1'b0;
    commit(K_REG, 16'h0018, 3'd6, 16'h0101, 16'h0, 16'h0);
    commit(K_REG, 16'h001A, 3'd7, 16'h0202, 16'h0, 16'h0);
    idle(3);

    // Overflow with out_ready low, inum gap after drain
    do_reset();
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 10; i++)
      commit(K_REG, 16'(16'h0100 + 2*i), 3'(i), 16'(16'hA000 + i), 16'h0, 16'h0);
    chk("ovf_two", ovf_cnt, 2);
    out_ready = 1'b1;
    idle(9);
    commit(K_REG, 16'h0200, 3'd1, 16'hBEEF, 16'h0, 16'h0);
    idle(2);

    // Full queue with simultaneous push and pop
    do_reset();
    trace_en = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++)
      commit(K_ST, 16'(16'h0300 + 2*i), 3'd0, 16'h0, 16'(16'h0400 + i), 16'(16'hC000 + i));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      commit(K_LD, 16'(16'h0500 + 2*i), 3'(i), 16'(16'hD000 + i), 16'(16'h0600 + i), 16'h0);
    chk("ovf_zero", ovf_cnt, 0);
    idle(10);

    // Halt with entries queued; later commits ignored; done after halt pops
    do_reset();
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++)
      commit(K_REG, 16'(16'h0700 + 2*i), 3'(i), 16'(16'hE000 + i), 16'h0, 16'h0);
    commit(K_HALT, 16'h0706, 3'd7, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    commit(K_REG, 16'h0708, 3'd1, 16'h1234, 16'h0, 16'h0);
    commit(K_ST,  16'h070A, 3'd1, 16'h0, 16'h0800, 16'h4321);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && m_state != M_DONE; i++) step();
    idle(2);
    chk("halt_done", done, 1);

    // Reset mid-drain discards entries and restarts counters
    do_reset();
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++)
      commit(K_REG, 16'(16'h0900 + 2*i), 3'(i), 16'(16'h5000 + i), 16'h0, 16'h0);
    commit(K_HALT, 16'h0906, 3'd0, 16'h0, 16'h0, 16'h0);
    step();
    chk("drain_state_valid", out_valid, 1);
    do_reset();
    trace_en = 1'b1; out_ready = 1'b1;
    step();
    commit(K_REG, 16'h0A00, 3'd2, 16'h0C0C, 16'h0, 16'h0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
